// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, no parity, 1 or 2 stop bits.
// Frame = start bit (low), 8 data bits, STOP_BITS stop bits (high); each
// bit lasts CLKS_PER_BIT cycles of fpga_clk. Both outputs are registered.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       fpga_clk,
  input  logic       nrst,
  input  logic       tx_en,
  input  logic [7:0] din,
  output logic       sout,
  output logic       busy_tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sout_q,  sout_d;
  logic             busy_q,  busy_d;
  logic             bit_done;

  assign bit_done = (cnt_q == CNT_LAST);
  assign sout     = sout_q;
  assign busy_tx  = busy_q;

  // State, counters, shift register and registered outputs
  always_ff @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; sout_d always carries the level for the coming bit so
  // the output register changes on the same edge as the bit boundary.
  // bit_q doubles as the stop-bit index while in STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        sout_d = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        bit_d  = '0;
        if (tx_en) begin
          shift_d = din;
          state_d = START;
          sout_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          sout_d  = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            sout_d  = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            sout_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        sout_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx;

  localparam int CLKS   = 4;
  localparam int FRAME1 = (9 + 1) * CLKS;

  logic       fpga_clk = 1'b0;
  logic       nrst     = 1'b1;
  logic       tx_en    = 1'b0;
  logic [7:0] din      = 8'h00;
  logic       sout, busy_tx;
  logic       tx_en2   = 1'b0;
  logic [7:0] din2     = 8'h00;
  logic       sout2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 fpga_clk = ~fpga_clk;

  uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(1)) u_dut (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_en(tx_en), .din(din),
    .sout(sout), .busy_tx(busy_tx)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) u_dut2 (
    .fpga_clk(fpga_clk), .nrst(nrst), .tx_en(tx_en2), .din(din2),
    .sout(sout2), .busy_tx(busy2)
  );

  // Reference model: a frame is a timeline of FRAME1 cycles; position p maps
  // to frame bit p/CLKS (0 = start, 1..8 = data LSB first, 9 = stop).
  logic       m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;

  always @(posedge fpga_clk or negedge nrst) begin
    if (!nrst) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      m_pos <= m_pos + 1;
      if (m_pos + 1 == FRAME1) m_active <= 1'b0;
    end else if (tx_en) begin
      m_active <= 1'b1;
      m_pos    <= 0;
      m_byte   <= din;
    end
  end

  function automatic logic exp_sout();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / CLKS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare_loop();
    forever begin
      @(negedge fpga_clk);
      check("cyc_sout", {31'd0, sout}, {31'd0, exp_sout()});
      check("cyc_busy", {31'd0, busy_tx}, {31'd0, m_active});
    end
  endtask

  // Called at a negedge: requests one frame, then samples mid-bit levels and
  // counts busy cycles until busy_tx falls (bounded).
  task automatic run_frame(input logic [7:0] b, input int chg_at, input logic [7:0] chg_val,
                           output int busy_n, output logic [9:0] bits);
    int k;
    din   = b;
    tx_en = 1'b1;
    @(negedge fpga_clk);
    tx_en  = 1'b0;
    busy_n = 0;
    bits   = '0;
    k      = 0;
    while (busy_tx === 1'b1 && k < 200) begin
      if (busy_n == chg_at) din = chg_val;
      if ((busy_n % CLKS) == 1 && (busy_n / CLKS) < 10) bits[busy_n/CLKS] = sout;
      busy_n++;
      k++;
      @(negedge fpga_clk);
    end
  endtask

  initial begin
    int         bn, bt, ri, idle_mid, lo, hi, k;
    logic [9:0] bits;
    logic       prev, order_bad;

    fork
      compare_loop();
    join_none

    // Reset behaviour, including before the first clock edge
    #1 nrst = 1'b0;
    #1;
    check("rst_pre_edge_sout", {31'd0, sout}, 32'd1);
    check("rst_pre_edge_busy", {31'd0, busy_tx}, 32'd0);
    #5;
    check("rst_edge1_sout", {31'd0, sout}, 32'd1);
    check("rst_edge1_busy", {31'd0, busy_tx}, 32'd0);
    tx_en = 1'b1;
    #10;
    check("rst_txen_sout", {31'd0, sout}, 32'd1);
    check("rst_txen_busy", {31'd0, busy_tx}, 32'd0);
    tx_en = 1'b0;
    #6 nrst = 1'b1;
    @(negedge fpga_clk);
    check("post_rst_sout", {31'd0, sout}, 32'd1);

    // Single frame of 0xEE
    run_frame(8'hEE, -1, 8'h00, bn, bits);
    check("ee_busy_len", bn, 40);
    check("ee_bits", {22'd0, bits}, {22'd0, 10'b1111011100});
    repeat (3) @(negedge fpga_clk);

    // Back-to-back frames with tx_en held for 70 cycles
    din = 8'hEE; tx_en = 1'b1;
    bt = 0; ri = 0; idle_mid = 0; prev = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge fpga_clk);
      if (i == 70) tx_en = 1'b0;
      if (busy_tx) bt++;
      else if (i <= 70) idle_mid++;
      if (busy_tx && !prev) ri++;
      prev = busy_tx;
      if (i > 70 && !busy_tx) break;
    end
    check("b2b_busy_total", bt, 80);
    check("b2b_frames", ri, 2);
    check("b2b_idle_gap", idle_mid, 1);
    repeat (2) @(negedge fpga_clk);

    // din changed mid-frame must not disturb the frame in flight
    run_frame(8'h95, 10, 8'hF0, bn, bits);
    check("x95_busy_len", bn, 40);
    check("x95_bits", {22'd0, bits}, {22'd0, 10'b1100101010});
    check("din_now_f0", {24'd0, din}, 32'hF0);
    repeat (2) @(negedge fpga_clk);
    run_frame(din, -1, 8'h00, bn, bits);
    check("xf0_bits", {22'd0, bits}, {22'd0, 10'b1111100000});
    repeat (2) @(negedge fpga_clk);

    // Reset during data bit 3 aborts the frame at once
    din = 8'h5A; tx_en = 1'b1;
    @(negedge fpga_clk);
    tx_en = 1'b0;
    repeat (17) @(negedge fpga_clk);
    check("mid_busy_before", {31'd0, busy_tx}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_sout", {31'd0, sout}, 32'd1);
    check("mid_rst_busy", {31'd0, busy_tx}, 32'd0);
    din = 8'hC3; tx_en = 1'b1;
    @(negedge fpga_clk);
    check("mid_rst_hold_busy", {31'd0, busy_tx}, 32'd0);
    @(negedge fpga_clk);
    nrst = 1'b1;
    run_frame(8'hC3, -1, 8'h00, bn, bits);
    check("after_rst_busy_len", bn, 40);
    check("after_rst_bits", {22'd0, bits}, {22'd0, 10'b1110000110});
    repeat (2) @(negedge fpga_clk);

    // Two-stop-bit instance sending 0x00
    din2 = 8'h00; tx_en2 = 1'b1;
    @(negedge fpga_clk);
    tx_en2 = 1'b0;
    lo = 0; hi = 0; bn = 0; k = 0; order_bad = 1'b0;
    while (busy2 === 1'b1 && k < 200) begin
      if (sout2 === 1'b0) begin
        lo++;
        if (hi != 0) order_bad = 1'b1;
      end else begin
        hi++;
      end
      bn++;
      k++;
      @(negedge fpga_clk);
    end
    check("sb2_low", lo, 36);
    check("sb2_high", hi, 8);
    check("sb2_busy_len", bn, 44);
    check("sb2_order", {31'd0, order_bad}, 32'd0);
    check("sb2_idle_sout", {31'd0, sout2}, 32'd1);

    // Randomized traffic with occasional asynchronous reset pulses
    repeat (2500) begin
      @(negedge fpga_clk);
      tx_en = ($urandom_range(0, 5) == 0);
      din   = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #3 nrst = 1'b0;
        #4 nrst = 1'b1;
      end
    end
    tx_en = 1'b0;
    repeat (50) @(negedge fpga_clk);
    check("final_idle_busy", {31'd0, busy_tx}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-003 SHALL have port fpga_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_en  input  1  transmit request, level-sensitive.
REQ-006 SHALL have port din  input  8  byte to transmit.
REQ-007 SHALL have port sout  output  1  serial line out, idle high.
REQ-008 SHALL have port busy_tx  output  1  high while a frame is in progress.

Function
REQ-009 SHALL use one clock (fpga_clk) and one asynchronous active-low reset (nrst); no other clock domains.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-011 Both outputs SHALL be driven directly from registers, with no combinational path from inputs.
REQ-012 In IDLE, sout SHALL be 1 and busy_tx SHALL be 0.
REQ-013 On a rising edge in IDLE with tx_en=1, the FSM SHALL:
- latch din into an internal shift register;
- enter START;
- set sout=0 and busy_tx=1, both visible immediately after that edge.
REQ-014 din SHALL be sampled only at the REQ-013 edge; later din changes SHALL NOT affect the current frame.
REQ-015 START SHALL hold sout=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 DATA SHALL shift out 8 bits, LSB first, each held on sout for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-017 STOP SHALL hold sout=1 for exactly STOP_BITS*CLKS_PER_BIT cycles.
REQ-018 At the end of STOP, the FSM SHALL return to IDLE and set busy_tx=0 on the same edge.
REQ-019 Total frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles, from the start edge to busy_tx falling.
REQ-020 tx_en SHALL be ignored while busy_tx=1; no queuing.
REQ-021 If tx_en is still 1 when IDLE is re-entered, the next frame SHALL start on the following edge, giving exactly 1 idle cycle (sout=1, busy_tx=0) between frames; this repeats for as long as tx_en stays high.
REQ-022 A clock-cycle counter (width ceil(log2(CLKS_PER_BIT))) SHALL reload to 0 at every bit boundary.
REQ-023 A 3-bit counter SHALL track the data bit index; it SHALL NOT wrap mid-frame.

Reset
REQ-024 While nrst=0, asynchronously and regardless of the clock:
- sout=1, busy_tx=0;
- state=IDLE;
- bit counter, cycle counter and shift register cleared to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (sout returns high); no partial frame SHALL resume after release.
REQ-026 After nrst deasserts, the first frame SHALL start on the first rising edge at which tx_en=1.

Verification (CLKS_PER_BIT=4, STOP_BITS=1, 10 ns clock)
REQ-027 Reset check: nrst=0 for 22 ns, tx_en=0 -> sout=1 and busy_tx=0 throughout, including before the first clock edge.
REQ-028 Single frame: tx_en=1, din=0xEE for one cycle, then tx_en=0 -> sout sequence per 4-cycle bit is 0 | 0,1,1,1,0,1,1,1 | 1; busy_tx high for exactly 40 cycles.
REQ-029 Back-to-back frames: tx_en held high for 70 cycles with din=0xEE -> two complete 40-cycle frames with a single idle cycle between them, then idle.
REQ-030 Mid-frame din change: start with din=0x95, change din to 0xF0 during DATA -> data bits 1,0,1,0,1,0,0,1 (0x95) unaffected. Then start a new frame with din=0xF0 -> data bits 0,0,0,0,1,1,1,1.
REQ-031 Reset mid-frame: nrst=0 during DATA bit 3 -> sout=1 and busy_tx=0 asynchronously. After release with tx_en=1, a fresh full-length frame of the current din is sent.
REQ-032 STOP_BITS=2 build: din=0x00 -> sout low for 36 cycles, then high for 8 cycles; busy_tx high for 44 cycles.
